// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - FIFO read-side drain: pops a 1-cycle-latency FIFO into a valid/ready stream.
// Optional delivered-word counter enabled by defining FIFO_RD_DRAIN_CNT_EN.
module fifo_rd_drain #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             flush_i,
    output logic             rd_enable_o,
    input  logic [WIDTH-1:0] rd_data_i,
    input  logic             empty_i,
    input  logic             error_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             flush_done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] rd_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic             inflight_q;
    logic             err_q, err_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;

    logic             pop_now;
    logic             returning;
    logic             capture;
    logic             cap_err;
    logic [2:0]       occupancy;

    assign m_valid_o = (cnt_q != 2'd0) && (state_q != S_FLUSH);
    assign m_data_o  = head_q ? buf1_q : buf0_q;
    assign err_o     = err_q;
    assign pop_now   = m_valid_o & m_ready_i;

    // Words returning while flushing (or on the flush cycle itself) are dropped.
    assign returning = inflight_q && (state_q != S_FLUSH) && !flush_i;
    assign capture   = returning & ~error_i;
    assign cap_err   = returning & error_i;

    // pop_now implies cnt_q >= 1, so this never goes negative.
    assign occupancy = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_now};

    assign flush_done_o = (state_q == S_FLUSH) && !flush_i && empty_i && !inflight_q;

    always_comb begin
        rd_enable_o = 1'b0;
        case (state_q)
            S_RUN:   rd_enable_o = !empty_i && (occupancy < 3'd2);
            S_FLUSH: rd_enable_o = !empty_i;
            default: rd_enable_o = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE:  if (enable_i) state_d = S_RUN;
                S_RUN:   if (!enable_i) state_d = S_IDLE;
                S_FLUSH: if (empty_i && !inflight_q) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        err_d  = err_q;
        if (flush_i) begin
            cnt_d  = 2'd0;
            head_d = 1'b0;
            tail_d = 1'b0;
            err_d  = 1'b0;
        end else begin
            if (capture) begin
                if (tail_q) buf1_d = rd_data_i;
                else        buf0_d = rd_data_i;
                tail_d = ~tail_q;
            end
            if (pop_now) begin
                head_d = ~head_q;
            end
            cnt_d = cnt_q + {1'b0, capture} - {1'b0, pop_now};
            if (cap_err) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= rd_enable_o;
            err_q      <= err_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef FIFO_RD_DRAIN_CNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (flush_i)      count_d = '0;
        else if (pop_now) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) count_q <= '0;
        else          count_q <= count_d;
    end

    assign rd_count_o = count_q;
`else
    assign rd_count_o = '0;
`endif

endmodule
